// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Segment patterns are active-low g..a, with the decimal point excluded.
package seg7_pkg;

   localparam int SETTLE_DEF  = 2;
   localparam int TIMEOUT_DEF = 1024;

   localparam logic [6:0] PAT_0 = 7'h40;
   localparam logic [6:0] PAT_1 = 7'h79;
   localparam logic [6:0] PAT_2 = 7'h24;
   localparam logic [6:0] PAT_3 = 7'h30;
   localparam logic [6:0] PAT_4 = 7'h19;
   localparam logic [6:0] PAT_5 = 7'h12;
   localparam logic [6:0] PAT_6 = 7'h02;
   localparam logic [6:0] PAT_7 = 7'h78;
   localparam logic [6:0] PAT_8 = 7'h00;
   localparam logic [6:0] PAT_9 = 7'h10;

   localparam logic [1:0] POS_SEC_ONES = 2'd0;
   localparam logic [1:0] POS_SEC_TENS = 2'd1;
   localparam logic [1:0] POS_MIN_ONES = 2'd2;
   localparam logic [1:0] POS_MIN_TENS = 2'd3;

   typedef logic [1:0] state_t;
   localparam state_t ST_WAIT   = 2'd0;
   localparam state_t ST_SETTLE = 2'd1;
   localparam state_t ST_HELD   = 2'd2;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Maps an active-low g..a segment pattern to a decimal digit.
// Any pattern outside the ten digit shapes is reported as invalid.
module seg7_pattern_lookup
   import seg7_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic       o_valid,
   output logic [3:0] o_digit
);

   always_comb begin
      o_valid = 1'b1;
      o_digit = 4'd0;
      case (i_seg)
         PAT_0:   o_digit = 4'd0;
         PAT_1:   o_digit = 4'd1;
         PAT_2:   o_digit = 4'd2;
         PAT_3:   o_digit = 4'd3;
         PAT_4:   o_digit = 4'd4;
         PAT_5:   o_digit = 4'd5;
         PAT_6:   o_digit = 4'd6;
         PAT_7:   o_digit = 4'd7;
         PAT_8:   o_digit = 4'd8;
         PAT_9:   o_digit = 4'd9;
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers MM:SS from a multiplexed 4-digit seven-segment scan.
//   state     | meaning
//   ST_WAIT   | no single digit selected; nothing is counted
//   ST_SETTLE | a digit is selected, counting identical {an, seg} cycles
//   ST_HELD   | digit captured; waiting for {an, seg} to change
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int SETTLE  = SETTLE_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] seg,
   input  logic [3:0] an,
   output logic [6:0] minutes,
   output logic [5:0] seconds,
   output logic       frame_valid,
   output logic       frame_err,
   output logic       stale
);

   localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);
   localparam logic [15:0] TO_LIMIT   = 16'(TIMEOUT);
   localparam logic [15:0] TO_PRE     = 16'(TIMEOUT - 1);

   logic [7:0]       r_seg, r_seg_d;
   logic [3:0]       r_an, r_an_d;
   state_t           r_state, w_state_nxt;
   logic [3:0]       r_cnt, w_cnt_nxt;
   logic             w_capture, w_sel_ok, w_changed;
   logic [1:0]       w_pos;
   logic             w_pat_ok;
   logic [3:0]       w_digit;
   logic [3:0]       r_mask, r_bad;
   logic [3:0][3:0]  r_dig;
   logic [15:0]      r_tcnt;
   logic             w_eval, w_frame_ok, w_timeout;
   logic [6:0]       r_minutes, w_min_val;
   logic [5:0]       r_seconds, w_sec_val;
   logic             r_fv, r_err, r_stale;

   seg7_pattern_lookup u_lookup (
      .i_seg   (r_seg[6:0]),
      .o_valid (w_pat_ok),
      .o_digit (w_digit)
   );

   always_comb begin
      w_sel_ok = 1'b1;
      w_pos    = POS_SEC_ONES;
      case (r_an)
         4'b1110: w_pos = POS_SEC_ONES;
         4'b1101: w_pos = POS_SEC_TENS;
         4'b1011: w_pos = POS_MIN_ONES;
         4'b0111: w_pos = POS_MIN_TENS;
         default: w_sel_ok = 1'b0;
      endcase
   end

   assign w_changed = ({r_an, r_seg} != {r_an_d, r_seg_d});

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      if (!w_sel_ok) begin
         w_state_nxt = ST_WAIT;
         w_cnt_nxt   = 4'd0;
      end else if (r_state == ST_WAIT || w_changed) begin
         w_state_nxt = ST_SETTLE;
         w_cnt_nxt   = 4'd1;
      end else if (r_state == ST_SETTLE) begin
         w_cnt_nxt   = r_cnt + 4'd1;
      end
      // With SETTLE = 1 the capture happens on the very first selected cycle.
      if (w_state_nxt == ST_SETTLE && w_cnt_nxt == SETTLE_CNT) begin
         w_capture   = 1'b1;
         w_state_nxt = ST_HELD;
      end
   end

   assign w_eval     = (r_mask == 4'hF);
   assign w_frame_ok = (r_bad == 4'h0) && (r_dig[POS_SEC_TENS] <= 4'd5) &&
                       (r_dig[POS_MIN_TENS] <= 4'd5);
   assign w_timeout  = !w_capture && (r_tcnt == TO_PRE);
   assign w_min_val  = 7'(r_dig[POS_MIN_TENS]) * 7'd10 + 7'(r_dig[POS_MIN_ONES]);
   assign w_sec_val  = 6'(r_dig[POS_SEC_TENS]) * 6'd10 + 6'(r_dig[POS_SEC_ONES]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg   <= 8'hFF;
         r_an    <= 4'hF;
         r_seg_d <= 8'hFF;
         r_an_d  <= 4'hF;
         r_state <= ST_WAIT;
         r_cnt   <= 4'd0;
      end else begin
         r_seg   <= seg;
         r_an    <= an;
         r_seg_d <= r_seg;
         r_an_d  <= r_an;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask <= 4'h0;
         r_bad  <= 4'h0;
         r_dig  <= '0;
      end else begin
         if (w_eval) begin
            r_mask <= 4'h0;
            r_bad  <= 4'h0;
         end else if (w_timeout) begin
            r_mask <= 4'h0;
         end
         // A capture in the evaluation cycle starts the next frame.
         if (w_capture) begin
            r_mask[w_pos] <= 1'b1;
            r_dig[w_pos]  <= w_digit;
            r_bad[w_pos]  <= !w_pat_ok;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt    <= 16'd0;
         r_minutes <= 7'd0;
         r_seconds <= 6'd0;
         r_fv      <= 1'b0;
         r_err     <= 1'b0;
         r_stale   <= 1'b1;
      end else begin
         if (w_capture)
            r_tcnt <= 16'd0;
         else if (r_tcnt != TO_LIMIT)
            r_tcnt <= r_tcnt + 16'd1;
         r_fv  <= w_eval && w_frame_ok;
         r_err <= w_eval && !w_frame_ok;
         if (w_eval && w_frame_ok) begin
            r_minutes <= w_min_val;
            r_seconds <= w_sec_val;
            r_stale   <= 1'b0;
         end else if (w_timeout) begin
            r_stale   <= 1'b1;
         end
      end
   end

   assign minutes     = r_minutes;
   assign seconds     = r_seconds;
   assign frame_valid = r_fv;
   assign frame_err   = r_err;
   assign stale       = r_stale;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with SETTLE = 2, TIMEOUT = 64.
// Inputs change 1 time unit after a rising edge; pulses are counted on falling edges.
module tb_seg7_scan_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] seg;
   logic [3:0] an;
   logic [6:0] minutes;
   logic [5:0] seconds;
   logic       frame_valid, frame_err, stale;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, fv_cnt = 0, err_cnt = 0, fv_cyc = 0, stale_rise_cyc = 0;
   logic stale_q = 1'b1;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.SETTLE(2), .TIMEOUT(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg         (seg),
      .an          (an),
      .minutes     (minutes),
      .seconds     (seconds),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .stale       (stale)
   );

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (frame_valid === 1'b1) begin
         fv_cnt <= fv_cnt + 1;
         fv_cyc <= cyc + 1;
      end
      if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
      if (stale === 1'b1 && stale_q !== 1'b1) stale_rise_cyc <= cyc + 1;
      stale_q <= stale;
   end

   function automatic logic [7:0] pat(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      drive(4'hF, 8'hFF, n);
   endtask

   task automatic scan(input int mt, input int mo, input int st, input int so);
      drive(4'b1110, pat(so), 4);
      drive(4'b1101, pat(st), 4);
      drive(4'b1011, pat(mo), 4);
      drive(4'b0111, pat(mt), 4);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (minutes !== 7'd0) begin n_fail++; $display("FAIL reset_minutes: got %0d expected 0", minutes); end
      n_tests++; if (seconds !== 6'd0) begin n_fail++; $display("FAIL reset_seconds: got %0d expected 0", seconds); end
      n_tests++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
      n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      n_tests++; if (stale !== 1'b1) begin n_fail++; $display("FAIL reset_stale: got %b expected 1", stale); end
      rst_n = 1'b1;
      idle(5);
   endtask

   task automatic test_basic();
      int f0, e0;
      f0 = fv_cnt; e0 = err_cnt;
      n_tests++; if (stale !== 1'b1) begin n_fail++; $display("FAIL basic_stale_before: got %b expected 1", stale); end
      scan(1, 2, 3, 4);
      idle(4);
      n_tests++; if (fv_cnt !== f0 + 1) begin n_fail++; $display("FAIL basic_fv_count: got %0d expected %0d", fv_cnt - f0, 1); end
      n_tests++; if (err_cnt !== e0) begin n_fail++; $display("FAIL basic_err_count: got %0d expected 0", err_cnt - e0); end
      n_tests++; if (minutes !== 7'd12) begin n_fail++; $display("FAIL basic_minutes: got %0d expected 12", minutes); end
      n_tests++; if (seconds !== 6'd34) begin n_fail++; $display("FAIL basic_seconds: got %0d expected 34", seconds); end
      n_tests++; if (stale !== 1'b0) begin n_fail++; $display("FAIL basic_stale_after: got %b expected 0", stale); end
   endtask

   task automatic test_back_to_back();
      int f0;
      f0 = fv_cnt;
      scan(5, 9, 5, 9);
      n_tests++; if (minutes !== 7'd59) begin n_fail++; $display("FAIL b2b_minutes_59: got %0d expected 59", minutes); end
      n_tests++; if (seconds !== 6'd59) begin n_fail++; $display("FAIL b2b_seconds_59: got %0d expected 59", seconds); end
      scan(0, 0, 0, 0);
      idle(3);
      n_tests++; if (minutes !== 7'd0) begin n_fail++; $display("FAIL b2b_minutes_0: got %0d expected 0", minutes); end
      n_tests++; if (seconds !== 6'd0) begin n_fail++; $display("FAIL b2b_seconds_0: got %0d expected 0", seconds); end
      n_tests++; if (fv_cnt !== f0 + 2) begin n_fail++; $display("FAIL b2b_fv_count: got %0d expected 2", fv_cnt - f0); end
   endtask

   task automatic test_bad_segment();
      int f0, e0;
      scan(1, 2, 3, 4);
      idle(3);
      f0 = fv_cnt; e0 = err_cnt;
      drive(4'b1110, pat(4), 4);
      drive(4'b1101, 8'hFF, 4);
      drive(4'b1011, pat(2), 4);
      drive(4'b0111, pat(1), 4);
      idle(3);
      n_tests++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL badseg_err_count: got %0d expected 1", err_cnt - e0); end
      n_tests++; if (fv_cnt !== f0) begin n_fail++; $display("FAIL badseg_fv_count: got %0d expected 0", fv_cnt - f0); end
      n_tests++; if (minutes !== 7'd12) begin n_fail++; $display("FAIL badseg_minutes_held: got %0d expected 12", minutes); end
      n_tests++; if (seconds !== 6'd34) begin n_fail++; $display("FAIL badseg_seconds_held: got %0d expected 34", seconds); end
      scan(4, 5, 0, 6);
      idle(3);
      n_tests++; if (fv_cnt !== f0 + 1) begin n_fail++; $display("FAIL badseg_recover_fv: got %0d expected 1", fv_cnt - f0); end
      n_tests++; if (minutes !== 7'd45) begin n_fail++; $display("FAIL badseg_recover_minutes: got %0d expected 45", minutes); end
      n_tests++; if (seconds !== 6'd6) begin n_fail++; $display("FAIL badseg_recover_seconds: got %0d expected 6", seconds); end
   endtask

   task automatic test_tens_range();
      int f0, e0;
      f0 = fv_cnt; e0 = err_cnt;
      scan(1, 0, 6, 0);
      idle(3);
      n_tests++; if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL sec_tens6_err: got %0d expected 1", err_cnt - e0); end
      n_tests++; if (seconds !== 6'd6) begin n_fail++; $display("FAIL sec_tens6_seconds_held: got %0d expected 6", seconds); end
      scan(6, 0, 0, 0);
      idle(3);
      n_tests++; if (err_cnt !== e0 + 2) begin n_fail++; $display("FAIL min_tens6_err: got %0d expected 2", err_cnt - e0); end
      n_tests++; if (minutes !== 7'd45) begin n_fail++; $display("FAIL min_tens6_minutes_held: got %0d expected 45", minutes); end
      n_tests++; if (fv_cnt !== f0) begin n_fail++; $display("FAIL tens_range_fv: got %0d expected 0", fv_cnt - f0); end
   endtask

   task automatic test_glitch();
      int f0, e0;
      f0 = fv_cnt; e0 = err_cnt;
      drive(4'b1110, pat(3), 2);
      drive(4'b1110, 8'hFF, 1);
      drive(4'b1110, pat(3), 1);
      drive(4'b1101, pat(4), 2);
      drive(4'b1101, pat(8), 1);
      drive(4'b1101, pat(4), 1);
      drive(4'b1011, pat(1), 2);
      drive(4'b1100, pat(1), 1);
      drive(4'b1011, pat(1), 1);
      drive(4'b0111, pat(2), 4);
      idle(4);
      n_tests++; if (fv_cnt !== f0 + 1) begin n_fail++; $display("FAIL glitch_fv: got %0d expected 1", fv_cnt - f0); end
      n_tests++; if (err_cnt !== e0) begin n_fail++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
      n_tests++; if (minutes !== 7'd21) begin n_fail++; $display("FAIL glitch_minutes: got %0d expected 21", minutes); end
      n_tests++; if (seconds !== 6'd43) begin n_fail++; $display("FAIL glitch_seconds: got %0d expected 43", seconds); end
   endtask

   task automatic test_stale();
      int f0;
      scan(1, 2, 3, 4);
      idle(2);
      n_tests++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_low_after_frame: got %b expected 0", stale); end
      idle(80);
      n_tests++; if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_high_after_idle: got %b expected 1", stale); end
      n_tests++; if (stale_rise_cyc - fv_cyc !== 63) begin n_fail++; $display("FAIL stale_rise_delay: got %0d expected 63 cycles after frame_valid", stale_rise_cyc - fv_cyc); end
      f0 = fv_cnt;
      scan(3, 3, 4, 4);
      idle(3);
      n_tests++; if (fv_cnt !== f0 + 1) begin n_fail++; $display("FAIL stale_resume_fv: got %0d expected 1", fv_cnt - f0); end
      n_tests++; if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_resume_clear: got %b expected 0", stale); end
      n_tests++; if (minutes !== 7'd33) begin n_fail++; $display("FAIL stale_resume_minutes: got %0d expected 33", minutes); end
   endtask

   task automatic test_reset_midframe();
      int f0;
      drive(4'b1110, pat(5), 4);
      drive(4'b1101, pat(4), 4);
      drive(4'b1011, pat(3), 4);
      idle(2);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (minutes !== 7'd0) begin n_fail++; $display("FAIL midrst_minutes: got %0d expected 0", minutes); end
      n_tests++; if (seconds !== 6'd0) begin n_fail++; $display("FAIL midrst_seconds: got %0d expected 0", seconds); end
      n_tests++; if (stale !== 1'b1) begin n_fail++; $display("FAIL midrst_stale: got %b expected 1", stale); end
      n_tests++; if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got fv=%b err=%b expected 0/0", frame_valid, frame_err); end
      rst_n = 1'b1;
      idle(2);
      f0 = fv_cnt;
      drive(4'b0111, pat(2), 4);
      idle(4);
      n_tests++; if (fv_cnt !== f0) begin n_fail++; $display("FAIL midrst_partial_discarded: got %0d expected 0", fv_cnt - f0); end
      drive(4'b1110, pat(5), 4);
      drive(4'b1101, pat(4), 4);
      drive(4'b1011, pat(3), 4);
      idle(4);
      n_tests++; if (fv_cnt !== f0 + 1) begin n_fail++; $display("FAIL midrst_full_frame_fv: got %0d expected 1", fv_cnt - f0); end
      n_tests++; if (minutes !== 7'd23) begin n_fail++; $display("FAIL midrst_minutes_after: got %0d expected 23", minutes); end
      n_tests++; if (seconds !== 6'd45) begin n_fail++; $display("FAIL midrst_seconds_after: got %0d expected 45", seconds); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_bad_segment();
      test_tens_range();
      test_glitch();
      test_stale();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter SETTLE, default 2: consecutive identical input cycles required before a digit is captured (range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 1024: cycles without a capture before the display is declared stale (range 16..65535).
REQ-003 SHALL have port clk  input  1: single clock for all logic.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port seg  input  8: active-low segments; bit7 = dp (ignored); bits 6..0 = g..a.
REQ-006 SHALL have port an  input  4: active-low digit enables; an[0] = sec ones, an[1] = sec tens, an[2] = min ones, an[3] = min tens.
REQ-007 SHALL have port minutes  output  7: last valid decoded minutes, 0..59.
REQ-008 SHALL have port seconds  output  6: last valid decoded seconds, 0..59.
REQ-009 SHALL have port frame_valid  output  1: one-cycle pulse when minutes/seconds update.
REQ-010 SHALL have port frame_err  output  1: one-cycle pulse when a completed frame is rejected.
REQ-011 SHALL have port stale  output  1: level; no valid frame since reset or timeout.

Function
REQ-012 SHALL register seg and an once, and use only the registered copies.
REQ-013 SHALL treat an as a digit select only when exactly one bit is low; 4'b1111 and multi-low values SHALL clear the stability count and capture nothing.
REQ-014 SHALL run FSM WAIT -> SETTLE -> HELD: WAIT goes to SETTLE on a valid select; SETTLE counts cycles with unchanged {an, seg}; any change returns to SETTLE with count 1 (or to WAIT if the select is invalid).
REQ-015 SHALL capture the digit in the cycle the count reaches SETTLE, then go to HELD; HELD SHALL not capture again until {an, seg} changes, and then behaves as REQ-014.
REQ-016 SHALL decode seg[6:0] against the ten patterns 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10 (digits 0..9); any other value SHALL mark that position bad.
REQ-017 SHALL keep a 4-bit capture mask and per-position digit/bad registers; a recapture of a position before the frame completes SHALL overwrite it (latest wins).
REQ-018 SHALL evaluate the frame in the cycle after the mask becomes 4'b1111, then clear the mask and all bad flags.
REQ-019 SHALL accept the frame only if no position is bad, sec tens <= 5, and min tens <= 5; otherwise pulse frame_err and hold minutes/seconds.
REQ-020 On accept, SHALL load minutes = 10*min_tens + min_ones and seconds = 10*sec_tens + sec_ones in the same cycle as the frame_valid pulse (latency: 1 cycle after the completing capture).
REQ-021 SHALL pulse frame_valid even if the value is unchanged.
REQ-022 SHALL count cycles since the last capture, saturating; at count == TIMEOUT SHALL set stale and clear the mask.
REQ-023 SHALL clear stale only with a frame_valid pulse; frame_err SHALL not clear it.
REQ-024 A capture in the same cycle as the timeout SHALL win: the counter resets, and neither stale nor the mask clear is applied.

Reset
REQ-025 While rst_n = 0: minutes = 0, seconds = 0, frame_valid = 0, frame_err = 0, stale = 1, FSM = WAIT, mask = 0, timeout counter = 0, input registers = 8'hFF/4'hF.
REQ-026 Reset mid-frame SHALL discard all partial captures; the first frame after release requires all four positions again.

Structure
REQ-027 Package seg7_pkg SHALL hold the ten segment pattern constants, the digit-position indices, the FSM state type, and the SETTLE/TIMEOUT defaults.
REQ-028 The combinational pattern-to-{valid, digit[3:0]} lookup SHALL be a sub-module named seg7_pattern_lookup; all other logic SHALL be in seg7_scan_decoder.

Verification (SETTLE = 2, TIMEOUT = 64 unless stated)
REQ-029 Scan 12:34 with each an held 4 cycles, order 1110, 1101, 1011, 0111 -> one frame_valid; minutes = 12, seconds = 34; stale 1 -> 0.
REQ-030 Scan 59:59 then 00:00 -> two frame_valid pulses; values 59/59 then 0/0.
REQ-031 On an = 1101, drive seg = 8'hFF in a frame after a valid 12:34 -> frame_err pulse; outputs stay 12/34; the next good frame is accepted.
REQ-032 Set sec tens = pattern 6 (8'h82) -> frame_err; drive 1-cycle an = 4'b1100 glitches and 1-cycle seg changes during a dwell -> no extra capture and no error.
REQ-033 Stop scanning (an = 4'hF) -> stale rises exactly 64 cycles after the last capture; resuming with a valid frame -> stale falls on that frame_valid.
REQ-034 Assert rst_n after 3 of 4 digits are captured -> all outputs at reset values; the next frame needs all 4 positions before frame_valid.
